// File: rtl/md_controller_if.sv
// Pipeline-facing signal bundle for the multiply/divide controller.
// The pipeline side drives the D/E-stage words and operands; the controller returns HI/LO, busy and the D-stage stall.
interface md_controller_if;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic        valid_E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        stall_D;

    modport master (
        output IR_D, IR_E, valid_E, RS_E, RT_E,
        input  HI, LO, busy, stall_D
    );

    modport slave (
        input  IR_D, IR_E, valid_E, RS_E, RT_E,
        output HI, LO, busy, stall_D
    );
endinterface

// File: rtl/md_controller.sv
// Multiply/divide sequencer: holds the shared unit busy for a fixed latency, commits HI/LO, and stalls D-stage HI/LO users.
//   state | meaning
//   IDLE  | unit free; accepts a start or mthi/mtlo from E
//   BUSY  | latency down-counter running; commit on terminal count
module md_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset_n,
    md_controller_if.slave md
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        load, commit;

    function automatic logic is_md(input logic [5:0] opc, input logic [5:0] fn);
        if (opc != 6'd0) return 1'b0;
        case (fn)
            6'h10, 6'h11, 6'h12, 6'h13,
            6'h18, 6'h19, 6'h1a, 6'h1b: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    logic [5:0] opc_d, fn_d, opc_e, fn_e;
    logic       r_e, md_D, start_E, mv_hi, mv_lo;
    logic       unused_ir;

    assign opc_d     = md.IR_D[31:26];
    assign fn_d      = md.IR_D[5:0];
    assign opc_e     = md.IR_E[31:26];
    assign fn_e      = md.IR_E[5:0];
    assign unused_ir = ^{md.IR_D[25:6], md.IR_E[25:6]};

    assign r_e     = (opc_e == 6'd0);
    assign md_D    = is_md(opc_d, fn_d);
    assign start_E = md.valid_E && r_e && (fn_e[5:2] == 4'b0110);
    assign mv_hi   = md.valid_E && r_e && (fn_e == 6'h11) && (state_q == IDLE);
    assign mv_lo   = md.valid_E && r_e && (fn_e == 6'h13) && (state_q == IDLE);

    assign md.busy    = (state_q == BUSY);
    assign md.stall_D = md_D && (md.busy || start_E);
    assign md.HI      = hi_q;
    assign md.LO      = lo_q;

    // op_q low two funct bits: 0 mult, 1 multu, 2 div, 3 divu
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_E) begin
                    load    = 1'b1;
                    cnt_d   = fn_e[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, qm, rm, q_s, r_s, q_u, r_u;
    logic        div_zero;

    // Signed division works on magnitudes so 0x80000000 / -1 stays well defined.
    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        a_mag    = a_q[31] ? -a_q : a_q;
        b_mag    = b_q[31] ? -b_q : b_q;
        qm       = div_zero ? 32'd0 : a_mag / b_mag;
        rm       = div_zero ? 32'd0 : a_mag % b_mag;
        q_s      = (a_q[31] ^ b_q[31]) ? -qm : qm;
        r_s      = a_q[31] ? -rm : rm;
        q_u      = div_zero ? 32'd0 : a_q / b_q;
        r_u      = div_zero ? 32'd0 : a_q % b_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= 2'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (load) begin
            op_q <= fn_e[1:0];
            a_q  <= md.RS_E;
            b_q  <= md.RT_E;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (commit) begin
            case (op_q)
                2'd0: {hi_q, lo_q} <= prod_s;
                2'd1: {hi_q, lo_q} <= prod_u;
                2'd2: if (!div_zero) begin hi_q <= r_s; lo_q <= q_s; end
                default: if (!div_zero) begin hi_q <= r_u; lo_q <= q_u; end
            endcase
        end else begin
            if (mv_hi) hi_q <= md.RS_E;
            if (mv_lo) lo_q <= md.RS_E;
        end
    end
endmodule

// File: tb/tb_md_controller.sv
// Directed bench for md_controller: stimulus pushes expected commits to a scoreboard, a monitor checks them when busy falls.
module tb_md_controller;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADDU  = 32'h0022_1821;
    localparam logic [5:0]  F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
    localparam logic [5:0]  F_MTHI = 6'h11, F_MTLO = 6'h13, F_MFHI = 6'h10, F_MFLO = 6'h12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    md_controller_if m();

    md_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (m)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, fn};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every busy falling edge is a commit that must match the oldest expectation.
    int   run_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            run_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (m.busy) run_len++;
            else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got HI=%0h LO=%0h expected none", m.HI, m.LO);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_len"}, 64'(run_len), 64'(e.len));
                    chk({e.name, "_hi"}, 64'(m.HI), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(m.LO), 64'(e.lo));
                end
                run_len = 0;
            end
            prev_busy = m.busy;
        end
    end

    always @(posedge clk) begin
        if (reset_n && m.busy && m.valid_E && m.IR_E[31:26] == 6'd0 && m.IR_E[5:2] == 4'b0110) begin
            errors++;
            $display("FAIL start_while_busy: got start with busy=1 expected no start");
        end
    end

    task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_t e;
        e.name = name; e.hi = hi; e.lo = lo; e.len = len;
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; issues one instruction in E for one cycle.
    task automatic issue(input string name, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic exp_stall);
        m.IR_E    = rtype(fn);
        m.RS_E    = rs;
        m.RT_E    = rt;
        m.valid_E = 1'b1;
        #1 chk({name, "_stall_start"}, 64'(m.stall_D), 64'(exp_stall));
        @(posedge clk);
        #1;
        m.valid_E = 1'b0;
        m.IR_E    = NOP;
    endtask

    task automatic wait_idle(input string name, input logic exp_stall, input int n);
        int cyc = 0;
        int ones = 0;
        while (m.busy && cyc < 40) begin
            if (m.stall_D) ones++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (m.busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 expected idle within 40 cycles", name);
        end
        chk({name, "_stall_cnt"}, 64'(ones), exp_stall ? 64'(n) : 64'd0);
        chk({name, "_stall_end"}, 64'(m.stall_D), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        m.IR_D = ADDU; m.IR_E = NOP; m.valid_E = 1'b0; m.RS_E = '0; m.RT_E = '0;
        #2;
        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_hi", 64'(m.HI), 64'd0);
        chk("rst_lo", 64'(m.LO), 64'd0);
        chk("rst_stall", 64'(m.stall_D), 64'd0);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue("mult", F_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle("mult", 1'b0, 0);

        push("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle("multu", 1'b0, 0);

        m.IR_D = rtype(F_MFLO);
        push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle("div", 1'b1, 10);
        m.IR_D = ADDU;

        issue("mthi", F_MTHI, 32'h11, 32'd0, 1'b0);
        chk("mthi_busy", 64'(m.busy), 64'd0);
        chk("mthi_hi", 64'(m.HI), 64'h11);
        chk("mthi_lo", 64'(m.LO), 64'hFFFF_FFFD);
        issue("mtlo", F_MTLO, 32'h22, 32'd0, 1'b0);
        chk("mtlo_busy", 64'(m.busy), 64'd0);
        chk("mtlo_hi", 64'(m.HI), 64'h11);
        chk("mtlo_lo", 64'(m.LO), 64'h22);

        m.IR_D = rtype(F_MFHI);
        push("divu0", 32'h11, 32'h22, 10);
        issue("divu0", F_DIVU, 32'h1234, 32'd0, 1'b1);
        wait_idle("divu0", 1'b1, 10);
        m.IR_D = ADDU;

        push("divovf", 32'h0, 32'h8000_0000, 10);
        issue("divovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle("divovf", 1'b0, 0);

        issue("abort", F_MULT, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_pre", 64'(m.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(m.busy), 64'd0);
        chk("abort_hi", 64'(m.HI), 64'd0);
        chk("abort_lo", 64'(m.LO), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_after_busy", 64'(m.busy), 64'd0);
        chk("abort_after_lo", 64'(m.LO), 64'd0);

        m.IR_E = rtype(F_MULT); m.RS_E = 32'd5; m.RT_E = 32'd7; m.valid_E = 1'b0;
        @(posedge clk); #1;
        chk("novalid_busy", 64'(m.busy), 64'd0);
        m.IR_E = rtype(F_MTHI); m.RS_E = 32'h55;
        @(posedge clk); #1;
        chk("novalid_mthi", 64'(m.HI), 64'd0);
        m.IR_E = NOP;
        repeat (8) @(posedge clk);
        #1;
        chk("novalid_lo", 64'(m.LO), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/md_controller.md
Name: md_controller

Overview:
- Sequences the shared multiply/divide resource and the HI/LO registers for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Holds the resource busy for a fixed latency, then commits HI/LO.
- Raises a D-stage stall whenever an HI/LO-touching instruction would otherwise enter E while the unit is occupied. It sits beside the forwarding/hazard logic and feeds its stall into the same D-stage freeze.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- IR_D  in  32  D-stage instruction word
- IR_E  in  32  E-stage instruction word
- valid_E  in  1  IR_E advances out of E this cycle (0 = bubble or frozen)
- RS_E  in  32  forwarded rs operand in E
- RT_E  in  32  forwarded rt operand in E
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- busy  out  1  unit occupied by a mult/div in progress
- stall_D  out  1  freeze F/D and insert a bubble into E

Behaviour:
- Decode: opcode IR[31:26]==0 with funct IR[5:0]:
  - 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu: start ops.
  - 0x11 mthi, 0x13 mtlo: move ops.
  - 0x10 mfhi, 0x12 mflo: reads.
  - Any other funct is ignored.
- md_D: IR_D is any of the eight ops above.
- start_E: valid_E && IR_E is mult/multu/div/divu.
- stall_D = md_D && (busy || start_E). This is combinational, with no cycle latency.
- Reset (async, reset_n=0): state IDLE, counter=0, busy=0, HI=0, LO=0, latched operands=0. Reset asserted mid-operation aborts the operation; no HI/LO commit occurs.
- FSM:
  - IDLE: on a clk edge with start_E, latch RS_E, RT_E and the op; load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - BUSY: busy=1. The counter decrements each edge. On the edge where counter==1, commit the result to HI/LO, set counter=0 and return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge, and the result is visible on HI/LO in the cycle busy falls.
  - start_E while BUSY is ignored. The stall_D contract makes this impossible in legal operation; the bench asserts it never occurs.
- mthi/mtlo (valid_E, state IDLE): HI or LO takes RS_E at the next edge. No busy is raised and the other register is untouched.
- Results:
  - mult: {HI,LO} = signed 64-bit RS*RT.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division boundaries:
  - Divisor==0: full DIV_CYCLES latency; HI and LO keep their previous values.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reads: mfhi/mflo never read HI/LO while busy, because stall_D holds them in D.
- Simultaneous events:
  - A commit edge coincides with a new start_E: cannot occur, because md_D stalled until busy fell.
  - A non-md instruction in D proceeds freely while busy.

Test Plan:
- Reset, then mult RS=0xFFFFFFFE (-2), RT=3 with valid_E -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_D=0 throughout for a non-md IR_D.
- multu 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div -7/2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Holding mflo in IR_D from the start cycle -> stall_D=1 for the start cycle plus 10 busy cycles, 0 when busy falls.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (one cycle each, busy stays 0). Then divu by 0 -> busy 10 cycles, HI/LO remain 0x11/0x22. Then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult; drive reset_n low on busy cycle 3 -> busy, HI, LO go 0 immediately (asynchronously); after release the unit is IDLE and no commit occurs.
- valid_E=0 with IR_E=mult -> no start and busy stays 0; mthi with valid_E=0 -> HI unchanged.
